// File: rtl/ntt_bu_sched.sv
// Address/control sequencer for an in-place radix-2 NTT over a 2R/2W coefficient RAM.
// Issues one butterfly read pair per cycle and replays it as a write pair after the BU latency.
module ntt_bu_sched #(
    parameter int ADW    = 5,
    parameter int BU_LAT = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [ADW-1:0] addrr_a_o,
    output logic [ADW-1:0] addrr_b_o,
    output logic           rd_valid_o,
    output logic [ADW-1:0] tw_idx_o,
    output logic [2:0]     stage_o,
    output logic           we_o,
    output logic [ADW-1:0] addrw_a_o,
    output logic [ADW-1:0] addrw_b_o
);

    localparam int CW = $clog2(BU_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [ADW-2:0] r_j, w_j_nxt;
    logic [2:0]     r_s, w_s_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic           w_issue;

    logic [3:0]     w_sh;
    logic [ADW-1:0] w_jx, w_len, w_grp, w_a, w_b, w_tw;

    logic           r_rd_vld;
    logic [ADW-1:0] r_tw;
    logic [BU_LAT:0] r_dl_vld;
    logic [ADW-1:0] r_dl_a [BU_LAT+1];
    logic [ADW-1:0] r_dl_b [BU_LAT+1];

    // w_sh = log2(len); butterfly j splits into group (upper bits) and offset (lower bits)
    assign w_sh  = 4'(ADW - 1) - {1'b0, r_s};
    assign w_jx  = {1'b0, r_j};
    assign w_len = ADW'(1) << w_sh;
    assign w_grp = w_jx >> w_sh;
    assign w_a   = (w_grp << (w_sh + 4'd1)) | (w_jx & (w_len - 1'b1));
    assign w_b   = w_a | w_len;
    assign w_tw  = (ADW'(1) << r_s) + w_grp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_READ;
                    w_j_nxt     = '0;
                    w_s_nxt     = '0;
                end
            end
            S_READ: begin
                w_issue   = 1'b1;
                w_cnt_nxt = '0;
                if (&r_j) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            S_DRAIN: begin
                // Wait until the stage's last write commits before reading the next stage
                if (r_cnt == CW'(BU_LAT)) begin
                    w_cnt_nxt = '0;
                    w_j_nxt   = '0;
                    if (r_s == 3'(ADW - 1)) begin
                        w_state_nxt = S_DONE;
                        w_s_nxt     = '0;
                    end else begin
                        w_state_nxt = S_READ;
                        w_s_nxt     = r_s + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // RAM read latency stage: valid and twiddle index line up with dout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_vld <= 1'b0;
            r_tw     <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_tw <= w_tw;
            end
        end
    end

    // Write delay line: each stage only loads on valid so the tail holds the last write pair
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dl_vld <= '0;
            for (int k = 0; k <= BU_LAT; k++) begin
                r_dl_a[k] <= '0;
                r_dl_b[k] <= '0;
            end
        end else begin
            r_dl_vld <= {r_dl_vld[BU_LAT-1:0], w_issue};
            if (w_issue) begin
                r_dl_a[0] <= w_a;
                r_dl_b[0] <= w_b;
            end
            for (int k = 1; k <= BU_LAT; k++) begin
                if (r_dl_vld[k-1]) begin
                    r_dl_a[k] <= r_dl_a[k-1];
                    r_dl_b[k] <= r_dl_b[k-1];
                end
            end
        end
    end

    assign busy_o     = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done_o     = (r_state == S_DONE);
    assign addrr_a_o  = busy_o ? w_a : '0;
    assign addrr_b_o  = busy_o ? w_b : '0;
    assign stage_o    = r_s;
    assign rd_valid_o = r_rd_vld;
    assign tw_idx_o   = r_tw;
    assign we_o       = r_dl_vld[BU_LAT];
    assign addrw_a_o  = r_dl_a[BU_LAT];
    assign addrw_b_o  = r_dl_b[BU_LAT];

endmodule

// File: tb/tb_ntt_bu_sched.sv
// Scoreboard bench for ntt_bu_sched: a loop-nest NTT reference pushes expected reads/writes/done,
// and a negedge monitor pops and compares whenever the scheduler presents them.
module tb_ntt_bu_sched;
    localparam int ADW    = 5;
    localparam int BU_LAT = 3;
    localparam int N      = 1 << ADW;
    localparam int HALF   = N / 2;
    localparam int PER    = HALF + 1 + BU_LAT;
    localparam int TOTAL  = ADW * PER;

    // Hand-computed butterflies: stage, index, top, bottom, twiddle
    localparam int H_S [6] = '{0, 0, 1, 2, 4, 4};
    localparam int H_J [6] = '{0, 15, 8, 5, 0, 15};
    localparam int H_A [6] = '{0, 15, 16, 9, 0, 30};
    localparam int H_B [6] = '{16, 31, 24, 13, 1, 31};
    localparam int H_TW[6] = '{1, 1, 3, 5, 16, 31};

    logic           clk_i   = 1'b0;
    logic           rst_i   = 1'b1;
    logic           start_i = 1'b0;
    logic           busy_o, done_o, rd_valid_o, we_o;
    logic [ADW-1:0] addrr_a_o, addrr_b_o, tw_idx_o, addrw_a_o, addrw_b_o;
    logic [2:0]     stage_o;

    ntt_bu_sched #(.ADW(ADW), .BU_LAT(BU_LAT)) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .addrr_a_o (addrr_a_o),
        .addrr_b_o (addrr_b_o),
        .rd_valid_o(rd_valid_o),
        .tw_idx_o  (tw_idx_o),
        .stage_o   (stage_o),
        .we_o      (we_o),
        .addrw_a_o (addrw_a_o),
        .addrw_b_o (addrw_b_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {int s; int j; int a; int b; int tw; int cyc;} rd_t;
    typedef struct {int a; int b; int cyc; bit last;} wr_t;

    rd_t rdq[$];
    wr_t wrq[$];
    int  doneq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: classic Cooley-Tukey block/offset loops, timed from the start cycle
    function automatic void push_run(input int t0);
        int len, j, issue;
        rd_t r;
        wr_t w;
        for (int s = 0; s < ADW; s++) begin
            len = N >> (s + 1);
            j   = 0;
            for (int blk = 0; blk < N; blk += 2 * len) begin
                for (int k = 0; k < len; k++) begin
                    issue  = t0 + 1 + s * PER + j;
                    r.s    = s;
                    r.j    = j;
                    r.a    = blk + k;
                    r.b    = blk + k + len;
                    r.tw   = (N / (2 * len)) + blk / (2 * len);
                    r.cyc  = issue + 1;
                    rdq.push_back(r);
                    w.a    = r.a;
                    w.b    = r.b;
                    w.cyc  = issue + 1 + BU_LAT;
                    w.last = (j == HALF - 1);
                    wrq.push_back(w);
                    j++;
                end
            end
        end
        doneq.push_back(t0 + TOTAL + 1);
    endfunction

    // Monitor
    rd_t            m_rd;
    wr_t            m_wr;
    int             m_done;
    logic [ADW-1:0] p_a = '0;
    logic [ADW-1:0] p_b = '0;
    logic [2:0]     p_s = '0;
    logic [N-1:0]   cov = '0;
    int             busy_cnt = 0;
    int             we_total = 0;

    always @(negedge clk_i) begin
        if (busy_o === 1'b1) busy_cnt++;
        if (rd_valid_o === 1'b1) begin
            if (rdq.size() == 0) begin
                chk("rd_unexpected", 64'd1, 64'd0);
            end else begin
                m_rd = rdq.pop_front();
                chk("rd_issue", {32'(cyc), 8'(p_s), 8'(p_a), 8'(p_b), 8'(tw_idx_o)},
                    {32'(m_rd.cyc), 8'(m_rd.s), 8'(m_rd.a), 8'(m_rd.b), 8'(m_rd.tw)});
                for (int h = 0; h < 6; h++) begin
                    if (m_rd.s == H_S[h] && m_rd.j == H_J[h])
                        chk("rd_hand", {8'(p_a), 8'(p_b), 8'(tw_idx_o)},
                            {8'(H_A[h]), 8'(H_B[h]), 8'(H_TW[h])});
                end
            end
        end
        if (we_o === 1'b1) begin
            we_total++;
            if (wrq.size() == 0) begin
                chk("we_unexpected", 64'd1, 64'd0);
            end else begin
                m_wr = wrq.pop_front();
                chk("wr_pair", {32'(cyc), 8'(addrw_a_o), 8'(addrw_b_o)},
                    {32'(m_wr.cyc), 8'(m_wr.a), 8'(m_wr.b)});
                chk("wr_distinct", 64'(addrw_a_o != addrw_b_o), 64'd1);
                cov[addrw_a_o] = 1'b1;
                cov[addrw_b_o] = 1'b1;
                if (m_wr.last) begin
                    chk("stage_cover", 64'(cov), 64'({N{1'b1}}));
                    cov = '0;
                end
            end
        end
        if (done_o === 1'b1) begin
            if (doneq.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                m_done = doneq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(m_done));
                chk("busy_total", 64'(busy_cnt), 64'(TOTAL));
                chk("busy_at_done", 64'(busy_o), 64'd0);
            end
            busy_cnt = 0;
        end
        p_a = addrr_a_o;
        p_b = addrr_b_o;
        p_s = stage_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic launch(output int t0);
        start_i = 1'b1;
        t0 = cyc;
        push_run(t0);
        tick(1);
        start_i = 1'b0;
    endtask

    int t0, w0;

    initial begin
        tick(2);
        chk("reset_outputs", 64'({busy_o, done_o, addrr_a_o, addrr_b_o, rd_valid_o, tw_idx_o,
                                  stage_o, we_o, addrw_a_o, addrw_b_o}), 64'd0);
        rst_i = 1'b0;
        w0 = we_total;
        tick(200);
        chk("idle_no_we", 64'(we_total - w0), 64'd0);
        chk("idle_busy_done", 64'({busy_o, done_o}), 64'd0);

        // Full run with a start pulse during busy and one in the DONE cycle
        launch(t0);
        w0 = we_total;
        tick(29);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(70);
        start_i = 1'b1;
        tick(1);
        chk("runA_we_count", 64'(we_total - w0), 64'(ADW * HALF));
        chk("runA_drained", 64'(rdq.size() + wrq.size() + doneq.size()), 64'd0);

        // Back-to-back start, then reset in the middle of stage 2
        launch(t0);
        tick(45);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        rdq.delete();
        wrq.delete();
        doneq.delete();
        busy_cnt = 0;
        cov = '0;
        w0 = we_total;
        tick(10);
        chk("rst_no_we", 64'(we_total - w0), 64'd0);
        chk("rst_idle", 64'({busy_o, done_o, rd_valid_o, we_o, stage_o}), 64'd0);

        // Fresh run after the mid-transform reset
        launch(t0);
        w0 = we_total;
        tick(TOTAL + 5);
        chk("runC_we_count", 64'(we_total - w0), 64'(ADW * HALF));
        chk("runC_drained", 64'(rdq.size() + wrq.size() + doneq.size()), 64'd0);
        chk("runC_idle", 64'({busy_o, done_o, we_o}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
